// File: rtl/ras_ctrl.sv
// Dual-slot front-end controller for the return address stack: serialises slot pushes/pops
// into one RAS op per cycle. Optional push/pop pair fusion when RAS_CTRL_PAIR_FUSE_EN is defined.
module ras_ctrl #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s0_valid,
    input  logic [1:0]    s0_type,
    input  logic [31:0]   s0_next_pc,
    input  logic          s1_valid,
    input  logic [1:0]    s1_type,
    input  logic [31:0]   s1_next_pc,
    input  logic          flush,
    input  logic [31:0]   ras_target_pc,
    output logic [1:0]    ras_type,
    output logic          ras_inst_bj,
    output logic [31:0]   ras_next_pc,
    output logic          stall,
    output logic          pred_valid,
    output logic          pred_slot,
    output logic [31:0]   pred_pc,
    output logic [CW-1:0] depth
);

    localparam logic [1:0] T_PUSH = 2'b01;
    localparam logic [1:0] T_POP  = 2'b10;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t        state_q, state_d;
    logic [1:0]    lat_type_q, lat_type_d;
    logic [31:0]   lat_pc_q, lat_pc_d;
    logic [CW-1:0] depth_q, depth_d;

    logic          op0, op1, fuse;
    logic          sel_valid, sel_slot;
    logic [1:0]    sel_type;
    logic [31:0]   sel_pc;
    logic          iss, stall_c, pv_c, ps_c;
    logic [1:0]    iss_type;
    logic [31:0]   iss_pc, ppc_c;

    assign op0 = s0_valid && (s0_type == T_PUSH || s0_type == T_POP);
    assign op1 = s1_valid && (s1_type == T_PUSH || s1_type == T_POP);
`ifdef RAS_CTRL_PAIR_FUSE_EN
    assign fuse = op0 && op1 && s0_type == T_PUSH && s1_type == T_POP;
`else
    assign fuse = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lat_type_d = lat_type_q;
        lat_pc_d   = lat_pc_q;
        depth_d    = depth_q;
        sel_valid  = 1'b0;
        sel_slot   = 1'b0;
        sel_type   = 2'b00;
        sel_pc     = 32'h0;
        stall_c    = 1'b0;
        pv_c       = 1'b0;
        ps_c       = 1'b0;
        ppc_c      = 32'h0;
        iss        = 1'b0;
        iss_type   = 2'b00;
        iss_pc     = 32'h0;

        // Pick at most one candidate op for this cycle; flush suppresses everything.
        if (flush) begin
            state_d    = IDLE;
            lat_type_d = 2'b00;
            lat_pc_d   = 32'h0;
        end else if (state_q == SECOND) begin
            sel_valid  = 1'b1;
            sel_slot   = 1'b1;
            sel_type   = lat_type_q;
            sel_pc     = lat_pc_q;
            state_d    = IDLE;
            lat_type_d = 2'b00;
            lat_pc_d   = 32'h0;
        end else if (fuse) begin
            pv_c  = 1'b1;
            ps_c  = 1'b1;
            ppc_c = s0_next_pc;
        end else if (op0) begin
            sel_valid = 1'b1;
            sel_type  = s0_type;
            sel_pc    = s0_next_pc;
            if (op1) begin
                lat_type_d = s1_type;
                lat_pc_d   = s1_next_pc;
                stall_c    = 1'b1;
                state_d    = SECOND;
            end
        end else if (op1) begin
            sel_valid = 1'b1;
            sel_slot  = 1'b1;
            sel_type  = s1_type;
            sel_pc    = s1_next_pc;
        end

        // An underflowing pop still consumed its step above but issues nothing.
        if (sel_valid && !(sel_type == T_POP && depth_q == '0)) begin
            iss      = 1'b1;
            iss_type = sel_type;
            iss_pc   = sel_pc;
            if (sel_type == T_POP) begin
                pv_c    = 1'b1;
                ps_c    = sel_slot;
                ppc_c   = ras_target_pc;
                depth_d = depth_q - CW'(1);
            end else if (depth_q != CW'(DEPTH)) begin
                depth_d = depth_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            lat_type_q <= 2'b00;
            lat_pc_q   <= 32'h0;
            depth_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_type_q <= lat_type_d;
            lat_pc_q   <= lat_pc_d;
            depth_q    <= depth_d;
        end
    end

    // Outputs are forced low while reset is held, even before the first edge.
    assign ras_inst_bj = resetn & iss;
    assign ras_type    = resetn ? iss_type : 2'b00;
    assign ras_next_pc = resetn ? iss_pc : 32'h0;
    assign stall       = resetn & stall_c;
    assign pred_valid  = resetn & pv_c;
    assign pred_slot   = resetn & ps_c;
    assign pred_pc     = resetn ? ppc_c : 32'h0;
    assign depth       = resetn ? depth_q : '0;

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Dual-slot front-end controller for the 8-entry return address stack. It sits between the two decode slots and the single-port RAS. It serialises call (push) and return (pop) requests from both slots into at most one RAS operation per cycle, and stalls the front end while a second operation is pending. It also returns the predicted return target to the slot that issued the pop, and tracks stack occupancy to suppress underflowing pops.

## Interface
Parameters:
- DEPTH, 8, RAS entry count; occupancy counter width is clog2(DEPTH)+1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- s0_valid / s1_valid  in  1  decode slot 0 / 1 holds an instruction; slot 0 is older.
- s0_type / s1_type  in  2  2'b01 PUSH (call), 2'b10 POP (return); 2'b00 and 2'b11 mean no RAS op.
- s0_next_pc / s1_next_pc  in  32  return address to push for that slot.
- flush  in  1  front-end redirect; drops any pending work.
- ras_target_pc  in  32  current top-of-stack value from the RAS (combinational).
- ras_type  out  2  op type driven to the RAS.
- ras_inst_bj  out  1  RAS op strobe; the RAS acts at the next rising edge.
- ras_next_pc  out  32  push data to the RAS.
- stall  out  1  front end must hold both slots unchanged next cycle.
- pred_valid  out  1  pop prediction is valid this cycle.
- pred_slot  out  1  slot that owns the prediction (0/1).
- pred_pc  out  32  predicted return target.
- depth  out  4  tracked occupancy, 0..8.

## Operation
- Op slot: valid=1 and type is PUSH or POP.
- States:
  - IDLE: evaluates the current pair.
  - SECOND: issues the latched slot-1 op; the live inputs are ignored in this state.
- IDLE, no op slot: ras_inst_bj=0, stall=0.
- IDLE, exactly one op slot: issue it this cycle, stall=0.
- IDLE, two op slots: issue slot 0 this cycle, latch slot 1 (type, next_pc), assert stall, go to SECOND.
- SECOND: issue the latched op, stall=0, return to IDLE.
- Issuing an op: drive ras_type, ras_next_pc, ras_inst_bj=1.
- POP prediction: pred_valid=1, pred_pc=ras_target_pc, pred_slot = the popping slot.
- depth on issue:
  - PUSH: depth+1, saturating at 8. A push at 8 is still issued; the RAS handles the overwrite.
  - POP: depth−1.
- Underflow: a POP with depth=0 is suppressed (ras_inst_bj=0, pred_valid=0, depth stays 0). It still consumes its slot/state step.
- flush has highest priority, including over reset-free state:
  - no op is issued that cycle, pred_valid=0, stall=0;
  - the latch is cleared and the state goes to IDLE;
  - depth is unchanged, because already-issued RAS ops are not undone.

## Timing
- All ras_*, pred_* and stall outputs are combinational from the state and inputs. State, latch and depth are registered on the rising edge of clk.
- Single op: latency 0 to the RAS strobe; the RAS updates at the following edge.
- Dual op: two consecutive cycles, stall high for exactly the first.
- During reset (resetn=0) every output is 0.
- After reset: state IDLE, depth 0, latch 0.
- Reset asserted in SECOND: the latched op is discarded.

## Configuration
- RAS_CTRL_PAIR_FUSE_EN defined: in IDLE, s0 PUSH plus s1 POP in the same cycle fuse.
  - No RAS op and no stall; depth is unchanged.
  - pred_valid=1, pred_slot=1, pred_pc=s0_next_pc.
- RAS_CTRL_PAIR_FUSE_EN undefined: that pair is serialised like any other dual op (push, then pop over two cycles with a stall).

## Test plan
- Single call: s0 PUSH, next_pc=0x0000_1004 → ras_inst_bj=1, ras_type=01, ras_next_pc=0x1004, stall=0; depth 0→1.
- Dual call: s0 PUSH 0x100, s1 PUSH 0x200 → cycle 0 issues 0x100 with stall=1; cycle 1 issues 0x200 with stall=0, while the live inputs change to garbage; depth=2.
- Return prediction: after the dual call, s1 POP with ras_target_pc=0x200 → pred_valid=1, pred_slot=1, pred_pc=0x200; depth 2→1.
- Underflow and saturation:
  - POP at depth 0 → ras_inst_bj=0, pred_valid=0, depth=0.
  - Nine PUSHes → depth stays 8; the ninth is still issued.
- Flush in SECOND → no op issued that cycle, stall=0, next cycle in IDLE; depth reflects only the slot-0 op.
- s0 PUSH 0x300 plus s1 POP:
  - with the macro → no RAS op, pred_pc=0x300, stall=0;
  - without it → two-cycle sequence, with pred_pc taken from ras_target_pc in cycle 1.
